// File: rtl/uart_tx.sv
// UART transmitter: one-byte holding buffer feeding an 8N1/8N2 shifter, LSB first.
// The line and BUSY are registered from the state, so they trail it by exactly one clock.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 200,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bitIdx_q, bitIdx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  buf_q, buf_d;
  logic        full_q, full_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        accept, load, baudDone;

  assign accept   = tx_valid_i & ~full_q;
  assign baudDone = (baud_q == BAUD_LAST);

  always_comb begin
    state_d  = state_q;
    baud_d   = baudDone ? '0 : baud_q + 16'd1;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d   = '0;
        bitIdx_d = '0;
        if (full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (baudDone) begin
          state_d  = DATA;
          bitIdx_d = '0;
        end
      end
      DATA: begin
        if (baudDone) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bitIdx_q == 3'd7) begin
            state_d  = STOP;
            bitIdx_d = '0;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (baudDone) begin
          if (bitIdx_q == STOP_LAST) begin
            if (full_q) begin
              load    = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Loading restarts the baud phase so every frame is timed from its own start bit.
    if (load) begin
      shift_d  = buf_q;
      baud_d   = '0;
      bitIdx_d = '0;
    end
  end

  // load needs full_q and accept needs ~full_q, so the two never coincide.
  always_comb begin
    full_d = full_q;
    buf_d  = buf_q;
    if (load) begin
      full_d = 1'b0;
    end
    if (accept) begin
      full_d = 1'b1;
      buf_d  = tx_data_i;
    end
  end

  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_q != IDLE);
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      buf_q    <= '0;
      full_q   <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      buf_q    <= buf_d;
      full_q   <= full_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign tx_ready_o = ~full_q;
  assign tx_o       = tx_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (one and two stop bits) driven by a handshake driver,
// with a line-decoding monitor per instance checking against a scoreboard of expected frames.
module tb_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    logic [7:0] b;
    int         start;
  } expT;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      valid;
  logic [1:0][7:0] data;
  logic [1:0]      ready;
  logic [1:0]      txl;
  logic [1:0]      busy;

  int  cyc = 0;
  int  nChecks = 0;
  int  nFail = 0;
  bit  monOn = 1'b0;
  int  lastAcc[2];
  int  lastExp[2];
  expT q0[$];
  expT q1[$];

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk_i     (clk),
    .rst_i     (rst),
    .tx_data_i (data[0]),
    .tx_valid_i(valid[0]),
    .tx_ready_o(ready[0]),
    .tx_o      (txl[0]),
    .busy_o    (busy[0])
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk_i     (clk),
    .rst_i     (rst),
    .tx_data_i (data[1]),
    .tx_valid_i(valid[1]),
    .tx_ready_o(ready[1]),
    .tx_o      (txl[1]),
    .busy_o    (busy[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic int frameLen(input int d);
    return (9 + ((d == 0) ? 1 : 2)) * CPB;
  endfunction

  function automatic void resetModel();
    for (int d = 0; d < 2; d++) begin
      lastAcc[d] = -1000;
      lastExp[d] = -1000;
    end
    q0.delete();
    q1.delete();
  endfunction

  // A byte leaves the buffer one clock before its start bit appears; a frame starts two
  // clocks after acceptance, or right after the previous frame if that is later.
  task automatic sendByte(input int d, input logic [7:0] b);
    int   waited;
    bit   done;
    int   acc;
    int   expStart;
    logic expReady;
    expT  e;
    waited = 0;
    done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      valid[1-d] = 1'b0;
      valid[d]   = 1'b1;
      expReady = !(cyc >= lastAcc[d] && cyc < lastExp[d] - 1);
      check($sformatf("dut%0d ready", d), 32'(ready[d]), 32'(expReady));
      if (ready[d] === 1'b1) begin
        data[d] = b;
        @(posedge clk);
        #1;
        acc      = cyc;
        expStart = (acc + 2 > lastExp[d] + frameLen(d)) ? acc + 2 : lastExp[d] + frameLen(d);
        lastAcc[d] = acc;
        lastExp[d] = expStart;
        e.b     = b;
        e.start = expStart;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        done = 1'b1;
      end else begin
        data[d] = 8'($urandom);
        waited++;
        if (waited > 200) begin
          nChecks++;
          nFail++;
          $display("[TB] FAIL dut%0d sendTimeout: waited %0d cycles, required ready within 200", d, waited);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic dropValid(input int d, input int n);
    @(negedge clk);
    valid[d] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL dut%0d drainTimeout: %0d frames outstanding, required 0",
               d, (d == 0) ? q0.size() : q1.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Decodes whole frames off the line, requiring every sample of a bit to agree and BUSY
  // to be high throughout, then compares byte and start cycle with the scoreboard.
  task automatic monitorLoop(input int d);
    int         idleBad;
    int         sb;
    int         s;
    int         badBits;
    int         badBusy;
    logic [7:0] got;
    logic [CPB-1:0] samp;
    logic       refBit;
    bit         aborted;
    expT        e;
    idleBad = 0;
    sb = (d == 0) ? 1 : 2;
    forever begin
      @(negedge clk);
      if (!monOn || rst) begin
        idleBad = 0;
        continue;
      end
      if (txl[d] !== 1'b0) begin
        if (busy[d] !== 1'b0) idleBad++;
      end else begin
        check($sformatf("dut%0d idleBusy", d), idleBad, 0);
        idleBad = 0;
        s       = cyc;
        badBits = 0;
        badBusy = 0;
        got     = '0;
        aborted = 1'b0;
        for (int k = 0; k < 9 + sb && !aborted; k++) begin
          for (int c = 0; c < CPB; c++) begin
            if (k != 0 || c != 0) @(negedge clk);
            if (!monOn || rst) aborted = 1'b1;
            samp[c] = txl[d];
            if (busy[d] !== 1'b1) badBusy++;
          end
          if (k == 0) begin
            refBit = 1'b0;
          end else if (k <= 8) begin
            refBit = samp[CPB/2];
            got[k-1] = refBit;
          end else begin
            refBit = 1'b1;
          end
          for (int c = 0; c < CPB; c++) begin
            if (samp[c] !== refBit) badBits++;
          end
        end
        if (!aborted) begin
          if (((d == 0) ? q0.size() : q1.size()) == 0) begin
            nChecks++;
            nFail++;
            $display("[TB] FAIL dut%0d unexpectedFrame: got byte 0x%0h at cycle %0d, required none", d, got, s);
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            check($sformatf("dut%0d byte", d), 32'(got), 32'(e.b));
            check($sformatf("dut%0d startCycle", d), s, e.start);
            check($sformatf("dut%0d bitShape", d), badBits, 0);
            check($sformatf("dut%0d busyInFrame", d), badBusy, 0);
          end
        end
      end
    end
  endtask

  initial monitorLoop(0);
  initial monitorLoop(1);

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d;
    int s0;
    int bad;
    rst   = 1'b1;
    valid = '0;
    data  = '0;
    resetModel();
    repeat (3) @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d resetTx", i), 32'(txl[i]), 32'd1);
      check($sformatf("dut%0d resetReady", i), 32'(ready[i]), 32'd1);
      check($sformatf("dut%0d resetBusy", i), 32'(busy[i]), 32'd0);
    end
    rst   = 1'b0;
    monOn = 1'b1;

    // Single frame from an idle line.
    sendByte(0, 8'h55);
    dropValid(0, 0);
    drain(0);
    check("dut0 idleTx", 32'(txl[0]), 32'd1);
    check("dut0 idleBusy", 32'(busy[0]), 32'd0);

    // Streaming with valid held high, then backpressure with junk data while not ready.
    sendByte(0, 8'hA5);
    sendByte(0, 8'h3C);
    sendByte(0, 8'h11);
    sendByte(0, 8'h22);
    sendByte(0, 8'h33);
    dropValid(0, 0);
    drain(0);

    // Two stop bits: consecutive starts must be 44 cycles apart.
    sendByte(1, 8'hFF);
    sendByte(1, 8'h81);
    dropValid(1, 0);
    drain(1);

    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, 1);
      sendByte(d, 8'($urandom));
      if ($urandom_range(0, 2) == 0) dropValid(d, $urandom_range(0, 60));
    end
    @(negedge clk);
    valid = '0;
    drain(0);
    drain(1);

    // Abort a frame during data bit 3 while a second byte waits in the buffer.
    monOn = 1'b0;
    sendByte(0, 8'h0F);
    s0 = lastExp[0];
    sendByte(0, 8'hE7);
    dropValid(0, 0);
    while (cyc < s0 + 4 * CPB + 1) @(negedge clk);
    check("dut0 preResetReady", 32'(ready[0]), 32'd0);
    check("dut0 preResetBusy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("dut0 abortTx", 32'(txl[0]), 32'd1);
    check("dut0 abortReady", 32'(ready[0]), 32'd1);
    check("dut0 abortBusy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txl[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b1) bad++;
    end
    check("dut0 postResetIdle", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serial UART transmitter: the upstream end of the link that the team's UART receiver samples. It accepts parallel bytes over a valid/ready handshake, buffers one byte, and serialises 8N1 (or 8N2) frames, LSB first, on TX. Baud timing comes from an internal counter of the system clock; no external divider is used.

Parameters:
CLKS_PER_BIT, 200, CLK cycles per serial bit (200 gives 250000 baud at 50 MHz); legal range 2..65535
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
CLK       input   1   system clock, all state on rising edge
RST       input   1   asynchronous, active-high reset
TX_DATA   input   8   byte to send; sampled only on an accepting edge
TX_VALID  input   1   producer has a byte on TX_DATA
TX_READY  output  1   holding buffer empty; a byte is accepted on an edge where TX_VALID=1 and TX_READY=1
TX        output  1   serial line, idle high
BUSY      output  1   high while a frame (start through last stop bit) is on the line

Behaviour:
- Reset (async assert): TX=1, TX_READY=1, BUSY=0, state=IDLE, buffer empty, bit counter=0, baud counter=0. Outputs take these values immediately on RST assertion, not at the next edge.
- Holding buffer: one byte plus a full flag. TX_READY is the inverse of the full flag, registered.
- Accept: on an edge with TX_VALID & TX_READY, the buffer loads TX_DATA, full is set, and TX_READY=0 from the next cycle. A producer may keep TX_VALID high. TX_DATA is ignored when TX_READY=0.
- States:
  - IDLE: TX=1, BUSY=0. If the buffer is full, move the byte into the shift register, clear full (TX_READY=1 next cycle), and enter START.
  - START: TX=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts 0..7.
  - STOP: TX=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - After STOP: if the buffer is full, go directly to START with the new byte, with zero idle cycles between frames. Otherwise go to IDLE.
- Latency: byte accepted at edge N (line idle) -> IDLE sees the buffer full at edge N+1 -> TX falls at edge N+2. Every bit period is exactly CLKS_PER_BIT cycles. Frame length is (9+STOP_BITS)*CLKS_PER_BIT cycles.
- BUSY=1 from the edge TX falls for the start bit until the final stop-bit period completes.
- Buffer refill: the buffer refills while a frame is shifting (TX_READY returns high the cycle after the shift register loads). This allows continuous streaming.
- Simultaneous events: the buffer is moved to the shift register on the same edge a new accept is offered. Because TX_READY is registered low, the accept cannot happen that cycle, so no byte is lost or duplicated.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. It is reset to 0 on entry to START, so the phase of each frame is independent of the previous one.
- Reset mid-frame: the frame is aborted, TX returns to 1 immediately, and any buffered byte is discarded.

Test Plan:
- CLKS_PER_BIT=4, STOP_BITS=1: send 0x55 -> TX low at acceptance edge +2. Then 1,0,1,0,1,0,1,0 each 4 cycles, stop high 4 cycles. Frame is 40 cycles total. BUSY is high for exactly 40 cycles.
- Back-to-back: hold TX_VALID with 0xA5 then 0x3C -> second start bit begins on the cycle after the first frame's stop bit ends, with no idle gap. TX_READY pulses high for exactly one accept per frame. Line bits are 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- Backpressure: present 0x11, 0x22, 0x33 while TX_READY=0 -> only bytes offered while TX_READY=1 appear on TX, in order. No corruption occurs when TX_DATA changes while not ready.
- STOP_BITS=2, CLKS_PER_BIT=4: send 0xFF -> start low 4 cycles, 32 high data cycles, stop high 8 cycles. The next frame starts no earlier than 44 cycles after the first start-bit edge.
- Reset mid-frame: assert RST during data bit 3 of 0x0F with a second byte buffered -> TX=1 and TX_READY=1 before the next CLK edge. After release, the line stays idle with no residual frame.
- Loopback at CLKS_PER_BIT=200: drive TX into the team's UART receiver with sequence 0x00, 0xFF, 0x5A, 0xC3 -> the receiver's data output matches each byte in order.
